// File: rtl/md_pkg.sv
// Shared encodings for the execute stage: ALU op codes, multiply/divide op
// codes, the MD unit state enum and the default busy durations.
package md_pkg;

    // Default busy durations of the multi-cycle unit.
    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // md_op encodings; 110 and 111 are no-ops.
    typedef enum logic [2:0] {
        MD_MULT  = 3'b000,
        MD_MULTU = 3'b001,
        MD_DIV   = 3'b010,
        MD_DIVU  = 3'b011,
        MD_MTHI  = 3'b100,
        MD_MTLO  = 3'b101
    } md_op_e;

    // MD unit sequencing state.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    // Existing ALU encoding; unlisted codes produce zero.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10
    } alu_op_e;

endpackage

// File: rtl/alu.sv
// Single-cycle combinational ALU of the execute stage.
module alu
    import md_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_out
);

    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0] shamt;
    assign shamt = alu_b[SH_W-1:0];

    // Result selection by operation code; unknown codes yield zero.
    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_ADD:  alu_out = alu_a + alu_b;
            ALU_SUB:  alu_out = alu_a - alu_b;
            ALU_AND:  alu_out = alu_a & alu_b;
            ALU_OR:   alu_out = alu_a | alu_b;
            ALU_XOR:  alu_out = alu_a ^ alu_b;
            ALU_NOR:  alu_out = ~(alu_a | alu_b);
            ALU_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            ALU_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
            ALU_SLL:  alu_out = alu_a << shamt;
            ALU_SRL:  alu_out = alu_a >> shamt;
            ALU_SRA:  alu_out = $signed(alu_a) >>> shamt;
            default:  alu_out = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at launch into shadow registers and committed to
// HI/LO when the busy countdown expires. Optional MDU_CANCEL_EN adds the
// md_cancel squash input.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] md_a,
    input  logic [WIDTH-1:0] md_b,
`ifdef MDU_CANCEL_EN
    input  logic             md_cancel,
`endif
    input  logic             md_sel,
    output logic [WIDTH-1:0] md_out,
    output logic             busy
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Full-width product; sign- or zero-extending to 2*WIDTH makes the
    // truncated product exact for both signed and unsigned operands.
    function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic is_signed);
        logic signed [2*WIDTH-1:0] ea;
        logic signed [2*WIDTH-1:0] eb;
        ea = {{WIDTH{is_signed & a[WIDTH-1]}}, a};
        eb = {{WIDTH{is_signed & b[WIDTH-1]}}, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}. Works on magnitudes so truncation is
    // toward zero and the remainder follows the dividend; MIN / -1 wraps
    // naturally to quotient MIN, remainder 0. Zero divisor is guarded only
    // to keep the datapath defined; its result is never committed.
    function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic is_signed);
        logic             neg_a;
        logic             neg_b;
        logic [WIDTH-1:0] ua;
        logic [WIDTH-1:0] ub;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        neg_a = is_signed & a[WIDTH-1];
        neg_b = is_signed & b[WIDTH-1];
        ua    = neg_a ? -a : a;
        ub    = neg_b ? -b : b;
        if (ub == '0) begin
            ub = {{(WIDTH-1){1'b0}}, 1'b1};
        end
        q = ua / ub;
        r = ua % ub;
        if (neg_a ^ neg_b) begin
            q = -q;
        end
        if (neg_a) begin
            r = -r;
        end
        return {r, q};
    endfunction

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] sh_hi_q, sh_hi_d;
    logic [WIDTH-1:0] sh_lo_q, sh_lo_d;
    logic             sh_we_q, sh_we_d;

    logic             cancel;
    logic             start_ok;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] quot;

`ifdef MDU_CANCEL_EN
    assign cancel = md_cancel;
`else
    assign cancel = 1'b0;
`endif
    assign start_ok = md_start & ~cancel;

    // Launch, countdown, commit and cancel sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        sh_hi_d = sh_hi_q;
        sh_lo_d = sh_lo_q;
        sh_we_d = sh_we_q;
        prod    = mul_full(md_a, md_b, ~md_op[0]);
        quot    = div_full(md_a, md_b, ~md_op[0]);
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    case (md_op)
                        MD_MULT, MD_MULTU: begin
                            sh_hi_d = prod[2*WIDTH-1:WIDTH];
                            sh_lo_d = prod[WIDTH-1:0];
                            sh_we_d = 1'b1;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = RUN;
                            busy_d  = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            sh_hi_d = quot[2*WIDTH-1:WIDTH];
                            sh_lo_d = quot[WIDTH-1:0];
                            sh_we_d = |md_b;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = RUN;
                            busy_d  = 1'b1;
                        end
                        MD_MTHI: hi_d = md_a;
                        MD_MTLO: lo_d = md_a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (cancel) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    if (sh_we_q) begin
                        hi_d = sh_hi_q;
                        lo_d = sh_lo_q;
                    end
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // Control and architectural state; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            sh_we_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            sh_we_q <= sh_we_d;
        end
    end

    // Shadow result datapath; only consumed after a launch reloads it.
    always_ff @(posedge clk) begin
        sh_hi_q <= sh_hi_d;
        sh_lo_q <= sh_lo_d;
    end

    assign busy   = busy_q;
    assign md_out = md_sel ? hi_q : lo_q;

endmodule

// File: rtl/stage_e_md.sv
// Execute stage: combinational ALU plus multi-cycle multiply/divide unit.
// Optional macro MDU_CANCEL_EN adds the md_cancel squash input.
module stage_e_md
    import md_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_out,
    input  logic             md_start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] md_a,
    input  logic [WIDTH-1:0] md_b,
`ifdef MDU_CANCEL_EN
    input  logic             md_cancel,
`endif
    input  logic             md_sel,
    output logic [WIDTH-1:0] md_out,
    output logic             busy
);

    alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_op (alu_op),
        .alu_out(alu_out)
    );

    md_unit #(
        .WIDTH      (WIDTH),
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_md_unit (
        .clk      (clk),
        .reset    (reset),
        .md_start (md_start),
        .md_op    (md_op),
        .md_a     (md_a),
        .md_b     (md_b),
`ifdef MDU_CANCEL_EN
        .md_cancel(md_cancel),
`endif
        .md_sel   (md_sel),
        .md_out   (md_out),
        .busy     (busy)
    );

endmodule

// File: tb/tb_stage_e_md.sv
// Self-checking bench for stage_e_md: directed cases plus randomized MD
// operations and ALU operands against a longint-based reference model.
module tb_stage_e_md;

    localparam int W      = 32;
    localparam int MULT_C = 5;
    localparam int DIV_C  = 10;
    localparam int LIMIT  = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  alu_a, alu_b, alu_out;
    logic [3:0]    alu_op;
    logic          md_start;
    logic [2:0]    md_op;
    logic [W-1:0]  md_a, md_b;
    logic          md_sel;
    logic [W-1:0]  md_out;
    logic          busy;
`ifdef MDU_CANCEL_EN
    logic          md_cancel;
`endif

    int checks = 0;
    int errors = 0;

    // Reference architectural state.
    logic [W-1:0] exp_hi, exp_lo;

    stage_e_md #(
        .WIDTH(W), .MULT_CYCLES(MULT_C), .DIV_CYCLES(DIV_C)
    ) dut (
        .clk(clk), .reset(reset),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .md_start(md_start), .md_op(md_op), .md_a(md_a), .md_b(md_b),
`ifdef MDU_CANCEL_EN
        .md_cancel(md_cancel),
`endif
        .md_sel(md_sel), .md_out(md_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hl(output logic [W-1:0] h, output logic [W-1:0] l);
        md_sel = 1'b0;
        #1 l = md_out;
        md_sel = 1'b1;
        #1 h = md_out;
    endtask

    task automatic chk_hl(input string tag, input logic [W-1:0] h, input logic [W-1:0] l);
        logic [W-1:0] gh, gl;
        read_hl(gh, gl);
        chk({tag, "_hi"}, gh, h);
        chk({tag, "_lo"}, gl, l);
    endtask

    function automatic int exp_cycles(input logic [2:0] op);
        if (op == 3'd0 || op == 3'd1) return MULT_C;
        if (op == 3'd2 || op == 3'd3) return DIV_C;
        return 0;
    endfunction

    // Architectural effect of one completed MD operation, from plain 64-bit math.
    task automatic model_apply(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin sp = sa * sb; exp_hi = sp[63:32]; exp_lo = sp[31:0]; end
            3'd1: begin up = ua * ub; exp_hi = up[63:32]; exp_lo = up[31:0]; end
            3'd2: if (b != 0) begin exp_lo = 32'(sa / sb); exp_hi = 32'(sa % sb); end
            3'd3: if (b != 0) begin exp_lo = 32'(ua / ub); exp_hi = 32'(ua % ub); end
            3'd4: exp_hi = a;
            3'd5: exp_lo = a;
            default: ;
        endcase
    endtask

    // Issue one MD op; optionally inject an ignored start or a reset at a
    // given busy cycle (0 = none). Checks busy length, no-bypass and result.
    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input int inj_at, input logic [2:0] inj_op,
                         input logic [W-1:0] inj_a, input logic [W-1:0] inj_b,
                         input int rst_at);
        int n;
        int expn;
        logic [W-1:0] gh, gl;
        expn = (rst_at > 0) ? rst_at : exp_cycles(op);
        md_op = op; md_a = a; md_b = b; md_start = 1'b1;
        step();
        md_start = 1'b0;
        n = 0;
        while (busy && n < LIMIT) begin
            n++;
            if (n == 1) chk({tag, "_nobypass"}, md_out, md_sel ? exp_hi : exp_lo);
            if (n == inj_at) begin
                md_op = inj_op; md_a = inj_a; md_b = inj_b; md_start = 1'b1;
            end
            if (n == rst_at) reset = 1'b1;
            step();
            md_start = 1'b0;
            reset = 1'b0;
        end
        if (rst_at > 0) begin
            exp_hi = '0;
            exp_lo = '0;
        end else begin
            model_apply(op, a, b);
        end
        chk({tag, "_busy"}, n, expn);
        read_hl(gh, gl);
        chk({tag, "_hi"}, gh, exp_hi);
        chk({tag, "_lo"}, gl, exp_lo);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return a << s;
            4'd9:  return a >> s;
            4'd10: return $signed(a) >>> s;
            default: return 32'd0;
        endcase
    endfunction

    initial begin
        reset = 1'b1; md_start = 1'b0; md_op = 3'd7; md_a = '0; md_b = '0; md_sel = 1'b0;
        alu_a = '0; alu_b = '0; alu_op = 4'd0;
`ifdef MDU_CANCEL_EN
        md_cancel = 1'b0;
`endif
        exp_hi = '0; exp_lo = '0;
        repeat (3) step();
        reset = 1'b0;
        step();

        chk("rst_busy", busy, 1'b0);
        chk_hl("rst", 32'h0, 32'h0);

        do_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 0, 3'd7, '0, '0, 0);
        chk_hl("mult_k", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        do_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 0, 3'd7, '0, '0, 0);
        chk_hl("multu_k", 32'h0000_0002, 32'hFFFF_FFFA);
        do_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 0, 3'd7, '0, '0, 0);
        chk_hl("div_k", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("divu0", 3'd3, 32'd7, 32'd0, 0, 3'd7, '0, '0, 0);
        chk_hl("divu0_k", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_op("minneg1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd7, '0, '0, 0);
        chk_hl("minneg1_k", 32'h0, 32'h8000_0000);

        do_op("mtlo", 3'd5, 32'h1234_5678, 32'd0, 0, 3'd7, '0, '0, 0);
        do_op("mthi", 3'd4, 32'hCAFE_BABE, 32'd0, 0, 3'd7, '0, '0, 0);
        chk_hl("mtx_k", 32'hCAFE_BABE, 32'h1234_5678);

        do_op("ign", 3'd0, 32'd3, 32'd4, 2, 3'd2, 32'd100, 32'd5, 0);
        chk_hl("ign_k", 32'h0, 32'd12);
        do_op("reissue", 3'd2, 32'd100, 32'd5, 0, 3'd7, '0, '0, 0);
        chk_hl("reissue_k", 32'h0, 32'd20);

        do_op("rstmid", 3'd2, 32'd99, 32'd7, 0, 3'd7, '0, '0, 3);
        repeat (DIV_C + 2) step();
        chk("rstmid_idle", busy, 1'b0);
        chk_hl("rstmid_k", 32'h0, 32'h0);

`ifdef MDU_CANCEL_EN
        begin
            int n;
            do_op("pre_hi", 3'd4, 32'h1, 32'd0, 0, 3'd7, '0, '0, 0);
            do_op("pre_lo", 3'd5, 32'h2, 32'd0, 0, 3'd7, '0, '0, 0);
            md_op = 3'd0; md_a = 32'd7; md_b = 32'd9; md_start = 1'b1;
            step();
            md_start = 1'b0;
            n = 1;
            step();
            n = 2;
            md_cancel = 1'b1;
            step();
            md_cancel = 1'b0;
            chk("cxl_busy", busy, 1'b0);
            chk("cxl_n", n, 2);
            chk_hl("cxl_k", 32'h1, 32'h2);
            repeat (MULT_C + 2) step();
            chk_hl("cxl_late", 32'h1, 32'h2);
            md_op = 3'd4; md_a = 32'hDEAD_0000; md_start = 1'b1; md_cancel = 1'b1;
            step();
            md_start = 1'b0; md_cancel = 1'b0;
            chk("cxl_start_busy", busy, 1'b0);
            chk_hl("cxl_start", 32'h1, 32'h2);
        end
`endif

        for (int i = 0; i < 120; i++) begin
            logic [2:0] op, iop;
            logic [W-1:0] a, b;
            int e, ia;
            op  = 3'($urandom_range(0, 7));
            iop = 3'($urandom_range(0, 7));
            a   = pick();
            b   = pick();
            e   = exp_cycles(op);
            ia  = (e > 0) ? $urandom_range(0, e) : 0;
            do_op("rnd", op, a, b, ia, iop, pick(), pick(), 0);
        end

        for (int i = 0; i < 60; i++) begin
            alu_op = 4'($urandom_range(0, 15));
            alu_a  = pick();
            alu_b  = pick();
            #1;
            chk("alu", alu_out, alu_ref(alu_op, alu_a, alu_b));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stage_e_md.md
Name: stage_e_md

Overview:
- Next-generation execute stage: the existing single-cycle ALU path plus a parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits between the D/E and E/M pipeline registers.
- Exports `busy` so the hazard unit stalls D on any MD-class instruction while an operation is in flight.
- Supports mult, multu, div, divu, mthi and mtlo. mfhi/mflo read through `md_out`.

Parameters:
- WIDTH, 32, datapath width of operands, ALU and HI/LO.
- MULT_CYCLES, 5, busy duration of mult/multu; legal range ≥1.
- DIV_CYCLES, 10, busy duration of div/divu; legal range ≥1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- alu_a  in  WIDTH  ALU operand A.
- alu_b  in  WIDTH  ALU operand B.
- alu_op  in  4  ALU operation, existing encoding.
- alu_out  out  WIDTH  combinational ALU result.
- md_start  in  1  launches md_op this cycle; qualified with the E-stage valid bit.
- md_op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; others are no-op.
- md_a  in  WIDTH  rs value, forwarded.
- md_b  in  WIDTH  rt value, forwarded.
- md_sel  in  1  read select: 0 = LO, 1 = HI.
- md_out  out  WIDTH  combinational read of the HI/LO register selected by md_sel.
- busy  out  1  registered; high while an operation is in flight.

Behaviour:
- Reset:
  - HI = LO = 0, busy = 0, state IDLE, counter = 0.
  - Reset dominates all other inputs, including mid-operation: the in-flight result is discarded.
- State IDLE:
  - md_start with mult/multu/div/divu:
    - Operands are latched.
    - The result is computed into internal shadow registers.
    - The counter is loaded with N = MULT_CYCLES or DIV_CYCLES.
    - Next state is RUN; busy = 1 from the next cycle.
  - md_start with mthi/mtlo: HI or LO takes md_a at that clock edge. Busy stays 0 and the state stays IDLE.
- State RUN:
  - The counter decrements each cycle.
  - busy is high for exactly N cycles.
  - On the edge where the counter reaches 1, HI/LO take the shadow values and the state returns to IDLE. Both become visible on the cycle busy falls.
- md_start while busy:
  - The request is ignored; the hazard unit guarantees it never happens.
- Back-to-back operation:
  - md_start in the first cycle with busy = 0 after a RUN is accepted normally.
- Arithmetic:
  - mult/multu: {HI, LO} = full 2·WIDTH signed or unsigned product.
  - div/divu: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - Signed MIN / -1: LO = MIN, HI = 0.
  - Divide by zero: HI/LO are left unchanged. The unit still runs busy for DIV_CYCLES.
- md_out:
  - Reflects HI/LO combinationally, with no bypass of an in-flight result.
  - mfhi/mflo stall on busy, enforced by the hazard unit.
- alu_out: purely combinational, independent of MD state.

Optional Feature:
- Macro: MDU_CANCEL_EN. When defined, adds input port md_cancel (1 bit).
- md_cancel high in RUN:
  - Next edge: state IDLE, busy = 0.
  - HI/LO are not written; the shadow result is dropped.
- md_cancel high in the same cycle as md_start: the start is suppressed, including mthi/mtlo.
- md_cancel has no effect in IDLE.
- Use: squashing an operation on exception or flush.
- Without the macro: no md_cancel port; an operation always completes.

Decomposition:
- Package md_pkg:
  - md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
  - State enum (IDLE, RUN).
  - Default cycle constants.
- Sub-module md_unit:
  - Contains the FSM, counter, shadow registers and HI/LO.
  - stage_e_md instantiates the existing alu plus md_unit.

Test Plan:
- mult, WIDTH=32, MULT_CYCLES=5: md_a = 0xFFFFFFFE (-2), md_b = 3.
  - busy high for exactly 5 cycles.
  - After busy falls: HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - multu on the same operands: HI = 0x00000002, LO = 0xFFFFFFFA.
- div, DIV_CYCLES=10, md_a = -7, md_b = 2.
  - busy high for 10 cycles.
  - LO = 0xFFFFFFFD (-3), HI = 0xFFFFFFFF (-1).
  - divu 7 / 0: busy for 10 cycles; HI/LO keep their prior values.
- mtlo 0x12345678, then mthi 0xCAFEBABE in consecutive cycles.
  - busy stays 0 throughout.
  - md_sel = 0 reads 0x12345678 the next cycle; md_sel = 1 reads 0xCAFEBABE.
- Start mult 3×4, then assert md_start with div 100/5 at busy cycle 2.
  - The second request is ignored.
  - After busy falls: LO = 12, HI = 0.
  - div re-issued on the first idle cycle gives LO = 20, HI = 0.
- reset asserted at busy cycle 3 of a div.
  - Next cycle: busy = 0, HI = LO = 0.
  - The div result is never written.
- MDU_CANCEL_EN defined: md_cancel at busy cycle 2 of a mult with HI/LO preloaded to 0x1/0x2.
  - Next cycle: busy = 0; HI = 0x1, LO = 0x2 retained.
